// File: rtl/lcd_cgram_readback.sv
// lcd_cgram_readback
//   Reads the eight pixel rows of one CGRAM character from an HD44780-style
//   LCD over a 4-bit bus. It issues a Set CGRAM Address command, waits for the
//   controller to settle, then performs eight two-nibble data reads. The LCD
//   auto-increments its address between reads.
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   start      readback request, only looked at while idle
//   char_idx   CGRAM character slot (0-7), captured when start is accepted
//   busy       operation in progress (not asserted in the DONE cycle)
//   done       one-cycle pulse after row 7 has been delivered
//   row_valid  one-cycle strobe qualifying row_data / row_index
//   row_data   low 5 bits of the assembled byte (held until the next row)
//   row_index  row number of row_data (held until the next row)
//   rs, rw, e  LCD control lines
//   data_out   nibble driven to D7..D4, data_oe enables the pad driver
//   data_in    nibble read back from D7..D4
module lcd_cgram_readback #(
  parameter int SETUP_CYCLES    = 2,
  parameter int PULSE_CYCLES    = 4,
  parameter int HOLD_CYCLES     = 2,
  parameter int CMD_WAIT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] char_idx,
  output logic       busy,
  output logic       done,
  output logic       row_valid,
  output logic [4:0] row_data,
  output logic [2:0] row_index,
  output logic       rs,
  output logic       rw,
  output logic       e,
  output logic [3:0] data_out,
  output logic       data_oe,
  input  logic [3:0] data_in
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_HI, S_CMD_LO, S_CMD_WAIT, S_RD_HI, S_RD_LO, S_EMIT, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q;
  logic [2:0]      row_cnt_q;
  logic            hi_bit_q;     // only bit 4 of the byte survives the mask
  logic [3:0]      lo_q;
  logic [4:0]      row_data_q;
  logic [2:0]      row_index_q;

  logic            xfer;
  logic [CW-1:0]   phase_lim;
  logic            phase_last;
  logic            pulse_end;

  // Current state is one of the four nibble-transfer states.
  assign xfer = (state_q == S_CMD_HI) || (state_q == S_CMD_LO) ||
                (state_q == S_RD_HI)  || (state_q == S_RD_LO);

  always_comb begin
    phase_lim = '0;
    case (phase_q)
      PH_SETUP: phase_lim = CW'(SETUP_CYCLES - 1);
      PH_PULSE: phase_lim = CW'(PULSE_CYCLES - 1);
      PH_HOLD:  phase_lim = CW'(HOLD_CYCLES - 1);
      default:  phase_lim = '0;
    endcase
  end

  assign phase_last = (cnt_q == phase_lim);
  assign pulse_end  = xfer && (phase_q == PH_PULSE) && phase_last;

  // Next-state, phase sequencing and bus outputs.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q + 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    row_valid = 1'b0;
    rs        = 1'b0;
    rw        = 1'b0;
    e         = 1'b0;
    data_out  = 4'b0000;
    data_oe   = 1'b0;

    if (xfer) begin
      e = (phase_q == PH_PULSE);
      if (phase_last) begin
        cnt_d = '0;
        case (phase_q)
          PH_SETUP: phase_d = PH_PULSE;
          PH_PULSE: phase_d = PH_HOLD;
          default:  phase_d = PH_SETUP;
        endcase
      end
    end

    case (state_q)
      S_IDLE: begin
        busy  = 1'b0;
        cnt_d = '0;
        if (start) state_d = S_CMD_HI;
      end
      S_CMD_HI: begin
        data_oe  = 1'b1;
        data_out = {2'b01, idx_q[2:1]};
        if (phase_q == PH_HOLD && phase_last) state_d = S_CMD_LO;
      end
      S_CMD_LO: begin
        data_oe  = 1'b1;
        data_out = {idx_q[0], 3'b000};
        if (phase_q == PH_HOLD && phase_last) state_d = S_CMD_WAIT;
      end
      S_CMD_WAIT: begin
        if (cnt_q == CW'(CMD_WAIT_CYCLES - 1)) state_d = S_RD_HI;
      end
      S_RD_HI: begin
        rs = 1'b1;
        rw = 1'b1;
        if (phase_q == PH_HOLD && phase_last) state_d = S_RD_LO;
      end
      S_RD_LO: begin
        rs = 1'b1;
        rw = 1'b1;
        if (phase_q == PH_HOLD && phase_last) state_d = S_EMIT;
      end
      S_EMIT: begin
        // Stay in read mode so rs/rw do not toggle between back-to-back rows.
        rs        = 1'b1;
        rw        = 1'b1;
        row_valid = 1'b1;
        cnt_d     = '0;
        state_d   = (row_cnt_q == 3'd7) ? S_DONE : S_RD_HI;
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Every state is entered at the start of a fresh SETUP phase.
    if (state_d != state_q) begin
      phase_d = PH_SETUP;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_SETUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      row_cnt_q   <= '0;
      hi_bit_q    <= 1'b0;
      lo_q        <= '0;
      row_data_q  <= '0;
      row_index_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;

      if (state_q == S_IDLE && start) begin
        idx_q     <= char_idx;
        row_cnt_q <= '0;
      end

      // Read data is sampled on the edge that ends the last PULSE cycle.
      if (pulse_end && state_q == S_RD_HI) hi_bit_q <= data_in[0];
      if (pulse_end && state_q == S_RD_LO) lo_q     <= data_in;

      if (state_q == S_RD_LO && state_d == S_EMIT) begin
        row_data_q  <= {hi_bit_q, lo_q};
        row_index_q <= row_cnt_q;
      end

      if (state_q == S_EMIT) row_cnt_q <= row_cnt_q + 3'd1;
    end
  end

  assign row_data  = row_data_q;
  assign row_index = row_index_q;

endmodule

// File: tb/tb_lcd_cgram_readback.sv
module tb_lcd_cgram_readback;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] char_idx = 3'd0;
  logic       busy, done, row_valid, rs, rw, e, data_oe;
  logic [4:0] row_data;
  logic [2:0] row_index;
  logic [3:0] data_out, data_in;

  lcd_cgram_readback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .char_idx(char_idx),
    .busy(busy), .done(done), .row_valid(row_valid), .row_data(row_data),
    .row_index(row_index), .rs(rs), .rw(rw), .e(e), .data_out(data_out),
    .data_oe(data_oe), .data_in(data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [2:0] idx;
    logic [4:0] data;
  } row_t;

  row_t       sb_q[$];
  int         done_q[$];
  logic [3:0] cmd_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  // LCD model: CGRAM contents, address counter, nibble phase trackers.
  logic [7:0] cg [64];
  logic [5:0] addr = 6'd0;
  bit         rd_ph = 1'b0;
  bit         wr_ph = 1'b0;
  logic [3:0] wr_hi = 4'd0;
  bit         rst_evt = 1'b0;

  assign data_in = rd_ph ? cg[addr][3:0] : cg[addr][7:4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard, bus protocol and LCD model updates.
  logic       prev_e = 1'b0, prev_rs = 1'b0, prev_rw = 1'b0;
  logic [3:0] prev_do = 4'd0;
  int         e_len = 0;
  row_t       got;

  always @(negedge clk) begin
    if (row_valid) begin
      if (sb_q.size() == 0) check("row_unexpected", 1, 0);
      else begin
        got = sb_q.pop_front();
        $display("row t=%0d idx=%0d data=%02h", cyc, row_index, row_data);
        check("row_time", cyc, got.t);
        check("row_index", row_index, got.idx);
        check("row_data", row_data, got.data);
      end
    end
    if (done) begin
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        $display("done t=%0d", cyc);
        check("done_time", cyc, done_q.pop_front());
        check("busy_in_done", busy, 0);
      end
    end
    if (rw) check("oe_while_rw", data_oe, 0);
    if (e && prev_e) check("bus_stable", {rs, rw, data_out}, {prev_rs, prev_rw, prev_do});
    if (e) e_len++;
    if (!e && prev_e) begin
      if (!rst_evt) begin
        check("e_width", e_len, 4);
        if (rw) begin
          if (rd_ph) addr = addr + 6'd1;
          rd_ph = !rd_ph;
        end else if (!rs) begin
          cmd_q.push_back(data_out);
          if (!wr_ph) wr_hi = data_out;
          else begin
            if (wr_hi[3:2] == 2'b01) addr = {wr_hi[1:0], data_out};
            rd_ph = 1'b0;
          end
          wr_ph = !wr_ph;
        end
      end
      e_len = 0;
    end
    prev_e  = e;
    prev_rs = rs;
    prev_rw = rw;
    prev_do = data_out;
  end

  task automatic push_op(input int t, input logic [2:0] idx);
    row_t r;
    for (int k = 0; k < 8; k++) begin
      r.t    = t + 83 + 17 * k;
      r.idx  = 3'(k);
      r.data = cg[{idx, 3'(k)}][4:0];
      sb_q.push_back(r);
    end
    done_q.push_back(t + 203);
  endtask

  task automatic do_start(input logic [2:0] idx, output int t);
    @(negedge clk);
    char_idx = idx;
    start    = 1'b1;
    t        = cyc;
    $display("start t=%0d idx=%0d", t, idx);
    push_op(t, idx);
    @(negedge clk);
    start    = 1'b0;
    char_idx = ~idx;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_ops();
    int b = 1000;
    while ((sb_q.size() != 0 || done_q.size() != 0) && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("op_timeout", (b > 0) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_cmd(input logic [2:0] idx);
    logic [3:0] n;
    if (cmd_q.size() < 2) check("cmd_count", cmd_q.size(), 2);
    else begin
      n = cmd_q.pop_front();
      check("cmd_hi", n, {2'b01, idx[2:1]});
      n = cmd_q.pop_front();
      check("cmd_lo", n, {idx[0], 3'b000});
    end
  endtask

  int t0;

  initial begin
    for (int a = 0; a < 64; a++) cg[a] = 8'h1F;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, done, row_valid, row_data, row_index, rs, rw, e, data_out, data_oe}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", {busy, done, row_valid, rs, rw, e, data_oe}, 0);

    // Slot 5, all rows 0x1F
    do_start(3'd5, t0);
    wait_ops();
    check_cmd(3'd5);
    check("hold_index", row_index, 7);
    check("hold_data", row_data, 5'h1F);

    // Rows 0xE0|row: nibble order and upper-bit masking
    for (int a = 0; a < 64; a++) cg[a] = 8'hE0 | 8'(a & 7);
    do_start(3'd2, t0);
    wait_ops();
    check_cmd(3'd2);

    // Random contents, stray start pulses mid-operation are ignored
    for (int a = 0; a < 64; a++) cg[a] = 8'($urandom);
    do_start(3'd3, t0);
    wait_until(t0 + 40);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 150);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ops();
    check_cmd(3'd3);

    // Reset during the row 3 read pulse, with a start in the reset cycle
    do_start(3'd6, t0);
    wait_until(t0 + 121);
    check("e_before_reset", e, 1);
    rst_evt = 1'b1;
    rst_n   = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    check("midop_reset_outs", {busy, done, row_valid, row_data, row_index, rs, rw, e, data_out, data_oe}, 0);
    @(negedge clk);
    check("start_in_reset_dropped", busy, 0);
    sb_q.delete();
    done_q.delete();
    cmd_q.delete();
    rd_ph   = 1'b0;
    wr_ph   = 1'b0;
    rst_evt = 1'b0;
    do_start(3'd1, t0);
    wait_ops();
    check_cmd(3'd1);

    // start held high: back-to-back operations
    @(negedge clk);
    char_idx = 3'd4;
    start    = 1'b1;
    t0       = cyc;
    $display("start_held t=%0d idx=4", t0);
    push_op(t0, 3'd4);
    push_op(t0 + 204, 3'd4);
    wait_until(t0 + 210);
    start = 1'b0;
    wait_ops();
    check_cmd(3'd4);
    check_cmd(3'd4);
    check("cmd_leftover", cmd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
